order_gate: RTL and testbench
=============================

ORDER_GATE -- requirements
Module: order_gate

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the order FIFO depth in entries; it is a power of two, minimum 2.
REQ-002 Parameter DW, default 8, SHALL set the order payload width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cb_halt  input  1  SHALL be the breaker halt command.
REQ-006 cb_throttle  input  1  SHALL be the breaker throttle command.
REQ-007 cb_throttle_phase  input  1  SHALL be the breaker metering phase, which toggles each cycle.
REQ-008 ord_valid  input  1  SHALL mark a valid inbound order.
REQ-009 ord_data  input  DW  SHALL carry the inbound order payload.
REQ-010 ord_ready  output  1  SHALL indicate that the gate accepts an inbound order this cycle.
REQ-011 out_valid  output  1  SHALL mark a released order at the head of the FIFO.
REQ-012 out_data  output  DW  SHALL carry the released order payload.
REQ-013 out_ready  input  1  SHALL indicate that downstream accepts the released order.
REQ-014 gate_state  output  2  SHALL report the current gate mode.
REQ-015 pass_count  output  8  SHALL count released orders.
REQ-016 drop_count  output  8  SHALL count discarded orders.

Function
REQ-017 gate_state SHALL be a registered FSM with states OPEN=0, METERED=1 and BLOCKED=2; each cycle, next state is BLOCKED if cb_halt=1, else METERED if cb_throttle=1, else OPEN; cb_halt has priority. This gives one cycle of latency from breaker input to gate mode.
REQ-018 An inbound transfer SHALL occur when ord_valid and ord_ready are both 1; an outbound transfer SHALL occur when out_valid and out_ready are both 1.
REQ-019 In OPEN or METERED, ord_ready SHALL equal (FIFO not full); an accepted order SHALL be pushed to the FIFO tail.
REQ-020 In BLOCKED, ord_ready SHALL be 1; an accepted order SHALL be discarded, not stored, and drop_count SHALL increment.
REQ-021 out_valid SHALL be 1 exactly when the FIFO is non-empty and either gate_state=OPEN, or gate_state=METERED with cb_throttle_phase=1; out_valid SHALL be 0 in BLOCKED.
REQ-022 out_data SHALL equal the FIFO head entry whenever out_valid=1; orders SHALL leave in arrival order.
REQ-023 Each outbound transfer SHALL pop the head and increment pass_count.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged, including when the FIFO is full at cycle start; ord_ready uses start-of-cycle occupancy only, so no combinational path exists from out_ready to ord_ready.
REQ-025 On the clock edge where gate_state changes from non-BLOCKED to BLOCKED, the FIFO SHALL be flushed to empty, and drop_count SHALL add the occupancy flushed.
REQ-026 If an inbound order is accepted on that same cycle, it SHALL also be discarded and counted, so the total added is occupancy+1.
REQ-027 pass_count and drop_count SHALL saturate at 255 and never wrap; a multi-entry increment SHALL clamp at 255.
REQ-028 FIFO read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL range from 0 to DEPTH inclusive.
REQ-029 Leaving BLOCKED SHALL restore normal acceptance in the first cycle that gate_state is OPEN or METERED, with an empty FIFO.

Reset
REQ-030 While rst_n=0, the block SHALL drive gate_state=OPEN, FIFO empty, out_valid=0, pass_count=0, drop_count=0 and ord_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all queued orders without counting them.
REQ-032 The first rising clk edge after rst_n is released SHALL evaluate the breaker inputs normally.

Structure
REQ-033 A shared package SHALL hold the gate-state encodings (OPEN, METERED, BLOCKED), the default DEPTH and the counter width (8).
REQ-034 The FIFO storage and pointers SHALL be one sub-module, order_fifo, with push, pop and flush inputs and full, empty and count outputs.
REQ-035 The FSM, counters and gating logic SHALL reside in order_gate.

Verification
REQ-036 The bench SHALL check OPEN flow: push orders 0x11, 0x22 and 0x33 with out_ready=1 -> out_data sequence 0x11, 0x22, 0x33 and pass_count=3.
REQ-037 The bench SHALL check metering: cb_throttle=1 with 4 orders queued and out_ready=1 -> releases only on cycles with cb_throttle_phase=1, so the queue drains in 8 cycles.
REQ-038 The bench SHALL check backpressure: out_ready=0 and 5 pushes offered with DEPTH=4 -> ord_ready=0 after the 4th push, and a push and pop in the same cycle while full keeps occupancy at 4.
REQ-039 The bench SHALL check halt flush: 3 orders queued, then cb_halt=1 -> one cycle later the FIFO is empty and drop_count=3; 2 further orders -> drop_count=5 and out_valid stays 0.
REQ-040 The bench SHALL check saturation: 260 orders offered in BLOCKED -> drop_count=255.
REQ-041 The bench SHALL check reset mid-operation: rst_n pulsed low with 2 orders queued -> all outputs return to their reset values.

Source files
------------

// File: rtl/order_gate_pkg.sv
// Shared definitions for the order gate: gate modes, default sizing and the
// saturating counter helper used by the pass/drop counters.
package order_gate_pkg;

    typedef enum logic [1:0] {
        GATE_OPEN    = 2'd0,
        GATE_METERED = 2'd1,
        GATE_BLOCKED = 2'd2
    } gate_state_t;

    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned CNT_W         = 8;
    localparam int unsigned INC_W         = 16;

    localparam logic [INC_W:0] SAT_MAX = (INC_W+1)'((2**CNT_W) - 1);

    // Add a possibly multi-entry increment, clamping at the counter maximum.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [INC_W-1:0] inc);
        logic [INC_W:0] sum;
        sum = (INC_W+1)'(a) + (INC_W+1)'(inc);
        if (sum > SAT_MAX) begin
            return CNT_W'(SAT_MAX);
        end
        return CNT_W'(sum);
    endfunction

endpackage

// File: rtl/order_gate_if.sv
// Valid/ready order channel; used for both the inbound and released order streams.
interface order_gate_if #(
    parameter int unsigned DW = 8
);
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/order_fifo.sv
// Order queue: circular buffer with power-of-two depth, synchronous flush,
// and push/pop in the same cycle allowed even when full.
module order_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DW-1:0]              wdata,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/order_gate.sv
// Circuit-breaker order gate: queues orders while open, meters releases when
// throttled, and discards (and counts) everything while halted.
module order_gate
    import order_gate_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned DW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cb_halt,
    input  logic             cb_throttle,
    input  logic             cb_throttle_phase,
    order_gate_if.slave      ord,
    order_gate_if.master     out,
    output logic [1:0]       gate_state,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    gate_state_t    state;
    gate_state_t    state_nxt;
    logic           full;
    logic           empty;
    logic [AW:0]    count;
    logic [DW-1:0]  head;
    logic           blocked;
    logic           entering_block;
    logic           in_fire;
    logic           out_fire;
    logic           push;
    logic [INC_W-1:0] drop_inc;

    // Halt dominates throttle; mode follows the breaker one cycle later.
    always_comb begin
        state_nxt = GATE_OPEN;
        if (cb_halt) begin
            state_nxt = GATE_BLOCKED;
        end else if (cb_throttle) begin
            state_nxt = GATE_METERED;
        end
    end

    assign blocked        = (state == GATE_BLOCKED);
    assign entering_block = !blocked && (state_nxt == GATE_BLOCKED);

    // ord.ready depends only on registered state, never on out.ready.
    assign ord.ready = blocked || !full;
    assign out.valid = !empty && ((state == GATE_OPEN) ||
                                  ((state == GATE_METERED) && cb_throttle_phase));
    assign out.data  = head;

    assign in_fire  = ord.valid && ord.ready;
    assign out_fire = out.valid && out.ready;
    assign push     = in_fire && !blocked && !entering_block;

    // An entry released on the flush cycle counts as passed, not dropped.
    always_comb begin
        drop_inc = '0;
        if (entering_block) begin
            drop_inc = INC_W'(count) - INC_W'(out_fire) + INC_W'(in_fire);
        end else if (blocked) begin
            drop_inc = INC_W'(in_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GATE_OPEN;
            pass_count <= '0;
            drop_count <= '0;
        end else begin
            state      <= state_nxt;
            pass_count <= sat_add(pass_count, INC_W'(out_fire));
            drop_count <= sat_add(drop_count, drop_inc);
        end
    end

    assign gate_state = state;

    order_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (out_fire),
        .flush (entering_block),
        .wdata (ord.data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_order_gate.sv
// Scoreboard bench for order_gate: queue of expected FIFO contents plus
// directed checks of open flow, metering, backpressure, flush, saturation, reset.
module tb_order_gate;
    import order_gate_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic cb_halt;
    logic cb_throttle;
    logic cb_throttle_phase;
    logic [1:0] gate_state;
    logic [7:0] pass_count;
    logic [7:0] drop_count;

    order_gate_if #(.DW(DW)) ord_if ();
    order_gate_if #(.DW(DW)) out_if ();

    order_gate #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cb_halt           (cb_halt),
        .cb_throttle       (cb_throttle),
        .cb_throttle_phase (cb_throttle_phase),
        .ord               (ord_if),
        .out               (out_if),
        .gate_state        (gate_state),
        .pass_count        (pass_count),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    gate_state_t   m_state;
    logic [7:0]    m_q[$];
    int            m_pass;
    int            m_drop;
    logic [7:0]    rel_q[$];
    logic          last_ordy;
    logic          ordy_log[5];

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // One clock cycle: drive, check at negedge against the model, advance model.
    task automatic step(input logic v, input logic [7:0] d, input logic ordy);
        logic exp_ordy, exp_ovalid, in_fire, out_fire;
        gate_state_t nxt;
        ord_if.valid      = v;
        ord_if.data       = d;
        out_if.ready      = ordy;
        cb_throttle_phase = ~cb_throttle_phase;
        @(negedge clk);
        exp_ordy   = (m_state == GATE_BLOCKED) || (m_q.size() < DEPTH);
        exp_ovalid = (m_q.size() != 0) &&
                     ((m_state == GATE_OPEN) || ((m_state == GATE_METERED) && cb_throttle_phase));
        check_eq("ord_ready", 16'(ord_if.ready), 16'(exp_ordy));
        check_eq("out_valid", 16'(out_if.valid), 16'(exp_ovalid));
        if (exp_ovalid) check_eq("out_data", 16'(out_if.data), 16'(m_q[0]));
        check_eq("gate_state", 16'(gate_state), 16'(m_state));
        check_eq("pass_count", 16'(pass_count), 16'(m_pass));
        check_eq("drop_count", 16'(drop_count), 16'(m_drop));
        last_ordy = ord_if.ready;
        if (out_if.valid && out_if.ready) rel_q.push_back(out_if.data);
        in_fire  = v && exp_ordy;
        out_fire = exp_ovalid && ordy;
        nxt = cb_halt ? GATE_BLOCKED : (cb_throttle ? GATE_METERED : GATE_OPEN);
        if (out_fire) begin
            void'(m_q.pop_front());
            m_pass = sat(m_pass + 1);
        end
        if (m_state != GATE_BLOCKED && nxt == GATE_BLOCKED) begin
            m_drop = sat(m_drop + m_q.size() + (in_fire ? 1 : 0));
            m_q.delete();
        end else if (m_state == GATE_BLOCKED) begin
            if (in_fire) m_drop = sat(m_drop + 1);
        end else if (in_fire) begin
            m_q.push_back(d);
        end
        m_state = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = GATE_OPEN;
        m_q.delete();
        m_pass = 0;
        m_drop = 0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_state"}, 16'(gate_state), 16'd0);
        check_eq({pfx, "_ovalid"}, 16'(out_if.valid), 16'd0);
        check_eq({pfx, "_ordy"}, 16'(ord_if.ready), 16'd1);
        check_eq({pfx, "_pass"}, 16'(pass_count), 16'd0);
        check_eq({pfx, "_drop"}, 16'(drop_count), 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cb_halt = 1'b0;
        cb_throttle = 1'b0;
        cb_throttle_phase = 1'b0;
        ord_if.valid = 1'b0;
        ord_if.data  = '0;
        out_if.ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Open flow
        rel_q.delete();
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check_eq("open_nrel", 16'(rel_q.size()), 16'd3);
        if (rel_q.size() == 3) begin
            check_eq("open_d0", 16'(rel_q[0]), 16'h11);
            check_eq("open_d1", 16'(rel_q[1]), 16'h22);
            check_eq("open_d2", 16'(rel_q[2]), 16'h33);
        end
        check_eq("open_pass", 16'(pass_count), 16'd3);

        // Metering: four queued, drained only on phase-1 cycles over 8 cycles
        cb_throttle = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h41 + i), 1'b0);
        rel_q.delete();
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        check_eq("meter_7cyc", 16'(rel_q.size()), 16'd3);
        step(1'b0, 8'h00, 1'b1);
        check_eq("meter_8cyc", 16'(rel_q.size()), 16'd4);
        if (rel_q.size() == 4) check_eq("meter_last", 16'(rel_q[3]), 16'h44);
        check_eq("meter_pass", 16'(pass_count), 16'd7);

        // Backpressure
        cb_throttle = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'h51 + i), 1'b0);
            ordy_log[i] = last_ordy;
        end
        check_eq("bp_ordy3", 16'(ordy_log[3]), 16'd1);
        check_eq("bp_ordy4", 16'(ordy_log[4]), 16'd0);
        rel_q.delete();
        step(1'b1, 8'h56, 1'b1);
        check_eq("bp_full_pop_ordy", 16'(last_ordy), 16'd0);
        step(1'b1, 8'h57, 1'b1);
        check_eq("bp_pushpop_ordy", 16'(last_ordy), 16'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
        check_eq("bp_nrel", 16'(rel_q.size()), 16'd5);
        if (rel_q.size() == 5) begin
            check_eq("bp_d0", 16'(rel_q[0]), 16'h51);
            check_eq("bp_d4", 16'(rel_q[4]), 16'h57);
        end
        check_eq("bp_pass", 16'(pass_count), 16'd12);

        // Halt flush
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h61 + i), 1'b0);
        cb_halt = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        check_eq("halt_drop3", 16'(drop_count), 16'd3);
        rel_q.delete();
        step(1'b1, 8'h71, 1'b1);
        step(1'b1, 8'h72, 1'b1);
        check_eq("halt_drop5", 16'(drop_count), 16'd5);
        check_eq("halt_norel", 16'(rel_q.size()), 16'd0);

        // Flush with an order accepted on the transition cycle
        cb_halt = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h81, 1'b0);
        step(1'b1, 8'h82, 1'b0);
        cb_halt = 1'b1;
        step(1'b1, 8'h83, 1'b0);
        check_eq("flush_plus1", 16'(drop_count), 16'd8);

        // Saturation
        for (int i = 0; i < 260; i++) step(1'b1, 8'(i), 1'b0);
        check_eq("sat_drop", 16'(drop_count), 16'd255);

        // Reset mid-operation
        cb_halt = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h91, 1'b0);
        step(1'b1, 8'h92, 1'b0);
        check_eq("pre_rst_ovalid", 16'(out_if.valid), 16'd1);
        ord_if.valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
